// File: rtl/bcd_pkg.sv
// Shared BCD digit type and digit constants for the vote counter.
package bcd_pkg;
    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;
    localparam bcd_digit_t BCD_ZERO      = 4'd0;
endpackage

// File: rtl/bcd_digit_step.sv
// One BCD digit of the ripple incrementer/decrementer; purely combinational.
module bcd_digit_step
    import bcd_pkg::*;
(
    input  bcd_digit_t digit,
    input  logic       up,
    input  logic       down,
    input  logic       cin,
    output bcd_digit_t next_digit,
    output logic       cout
);

    always_comb begin
        next_digit = digit;
        cout       = 1'b0;
        if (cin && up && !down) begin
            if (digit >= BCD_MAX_DIGIT) begin
                next_digit = BCD_ZERO;
                cout       = 1'b1;
            end else begin
                next_digit = digit + 4'd1;
            end
        end else if (cin && down && !up) begin
            if (digit == BCD_ZERO) begin
                next_digit = BCD_MAX_DIGIT;
                cout       = 1'b1;
            end else begin
                next_digit = digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_vote_counter.sv
// Packed-BCD up/down vote counter with button edge detection, load validation
// and wrap-or-saturate behaviour at the range limits.
module bcd_vote_counter
    import bcd_pkg::*;
#(
    parameter int                   DIGITS  = 3,
    parameter int                   WRAP    = 1,
    parameter logic [4*DIGITS-1:0]  MAX_BCD = {DIGITS{4'h9}}
) (
    input  logic                  clockat,
    input  logic                  reset,
    input  logic                  inc,
    input  logic                  dec,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   count,
    output logic                  carry,
    output logic                  borrow,
    output logic                  full,
    output logic                  load_err
);

    logic [4*DIGITS-1:0] r_count;
    logic                r_inc_q;
    logic                r_dec_q;
    logic                r_carry;
    logic                r_borrow;
    logic                r_load_err;

    logic                w_inc_evt;
    logic                w_dec_evt;
    logic                w_up;
    logic                w_down;
    logic                w_at_max;
    logic                w_at_zero;
    logic                w_load_ok;
    logic [4*DIGITS-1:0] w_stepped;
    logic [DIGITS:0]     w_ripple;
    logic [4*DIGITS-1:0] w_count_nxt;
    logic                w_carry_nxt;
    logic                w_borrow_nxt;
    logic                w_load_err_nxt;

    assign w_inc_evt = inc & ~r_inc_q;
    assign w_dec_evt = dec & ~r_dec_q;
    // Simultaneous up and down edges cancel out entirely.
    assign w_up      = w_inc_evt & ~w_dec_evt;
    assign w_down    = w_dec_evt & ~w_inc_evt;
    assign w_at_max  = (r_count == MAX_BCD);
    assign w_at_zero = (r_count == '0);

    assign w_ripple[0] = w_up | w_down;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_step u_step (
            .digit      (r_count[4*g +: 4]),
            .up         (w_up),
            .down       (w_down),
            .cin        (w_ripple[g]),
            .next_digit (w_stepped[4*g +: 4]),
            .cout       (w_ripple[g+1])
        );
    end

    always_comb begin
        w_load_ok = (load_value <= MAX_BCD);
        for (int i = 0; i < DIGITS; i++) begin
            if (load_value[4*i +: 4] > BCD_MAX_DIGIT) begin
                w_load_ok = 1'b0;
            end
        end
    end

    always_comb begin
        w_count_nxt    = r_count;
        w_carry_nxt    = 1'b0;
        w_borrow_nxt   = 1'b0;
        w_load_err_nxt = 1'b0;
        if (clear) begin
            w_count_nxt = '0;
        end else if (load) begin
            if (w_load_ok) begin
                w_count_nxt = load_value;
            end else begin
                w_load_err_nxt = 1'b1;
            end
        end else if (w_up) begin
            // Full scale may be below all-9s, so compare against MAX_BCD too.
            if (w_at_max || w_ripple[DIGITS]) begin
                w_carry_nxt = 1'b1;
                w_count_nxt = (WRAP != 0) ? '0 : r_count;
            end else begin
                w_count_nxt = w_stepped;
            end
        end else if (w_down) begin
            if (w_at_zero || w_ripple[DIGITS]) begin
                w_borrow_nxt = 1'b1;
                w_count_nxt  = (WRAP != 0) ? MAX_BCD : r_count;
            end else begin
                w_count_nxt = w_stepped;
            end
        end
    end

    always_ff @(posedge clockat) begin
        if (reset) begin
            r_count    <= '0;
            r_inc_q    <= 1'b0;
            r_dec_q    <= 1'b0;
            r_carry    <= 1'b0;
            r_borrow   <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_count    <= w_count_nxt;
            r_inc_q    <= inc;
            r_dec_q    <= dec;
            r_carry    <= w_carry_nxt;
            r_borrow   <= w_borrow_nxt;
            r_load_err <= w_load_err_nxt;
        end
    end

    assign count    = r_count;
    assign carry    = r_carry;
    assign borrow   = r_borrow;
    assign load_err = r_load_err;
    assign full     = w_at_max;

endmodule

// File: tb/tb_bcd_vote_counter.sv
// Directed scoreboard bench: one wrapping and one saturating counter instance.
module tb_bcd_vote_counter;

    logic        clockat = 1'b0;
    logic [1:0]  reset, inc, dec, clear, load;
    logic [11:0] lv0, lv1;
    logic [11:0] count0, count1;
    logic        carry0, carry1, borrow0, borrow1, full0, full1, lerr0, lerr1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          dut;
        logic [11:0] cnt;
        logic        car;
        logic        bor;
        logic        lerr;
        logic        full;
    } exp_t;

    exp_t sb[$];

    always #5 clockat = ~clockat;

    bcd_vote_counter #(.DIGITS(3), .WRAP(1)) u_wrap (
        .clockat(clockat), .reset(reset[0]), .inc(inc[0]), .dec(dec[0]),
        .clear(clear[0]), .load(load[0]), .load_value(lv0),
        .count(count0), .carry(carry0), .borrow(borrow0), .full(full0),
        .load_err(lerr0)
    );

    bcd_vote_counter #(.DIGITS(3), .WRAP(0)) u_sat (
        .clockat(clockat), .reset(reset[1]), .inc(inc[1]), .dec(dec[1]),
        .clear(clear[1]), .load(load[1]), .load_value(lv1),
        .count(count1), .carry(carry1), .borrow(borrow1), .full(full1),
        .load_err(lerr1)
    );

    task automatic step(input int d, input logic r, input logic i, input logic dn,
                        input logic cl, input logic ld, input logic [11:0] v,
                        input logic [11:0] ec, input logic ecar, input logic ebor,
                        input logic elerr, input string tag);
        exp_t e, got;
        logic [11:0] oc;
        logic        ocar, obor, olerr, ofull;
        reset[d] = r;
        inc[d]   = i;
        dec[d]   = dn;
        clear[d] = cl;
        load[d]  = ld;
        if (d == 0) lv0 = v; else lv1 = v;
        e.dut  = d;
        e.cnt  = ec;
        e.car  = ecar;
        e.bor  = ebor;
        e.lerr = elerr;
        e.full = (ec == 12'h999);
        sb.push_back(e);
        @(posedge clockat);
        #1;
        got = sb.pop_front();
        oc    = (got.dut == 0) ? count0  : count1;
        ocar  = (got.dut == 0) ? carry0  : carry1;
        obor  = (got.dut == 0) ? borrow0 : borrow1;
        olerr = (got.dut == 0) ? lerr0   : lerr1;
        ofull = (got.dut == 0) ? full0   : full1;
        checks++;
        assert (oc === got.cnt) else begin
            errors++;
            $error("FAIL %s count observed=%h expected=%h", tag, oc, got.cnt);
        end
        checks++;
        assert (ocar === got.car) else begin
            errors++;
            $error("FAIL %s carry observed=%b expected=%b", tag, ocar, got.car);
        end
        checks++;
        assert (obor === got.bor) else begin
            errors++;
            $error("FAIL %s borrow observed=%b expected=%b", tag, obor, got.bor);
        end
        checks++;
        assert (olerr === got.lerr) else begin
            errors++;
            $error("FAIL %s load_err observed=%b expected=%b", tag, olerr, got.lerr);
        end
        checks++;
        assert (ofull === got.full) else begin
            errors++;
            $error("FAIL %s full observed=%b expected=%b", tag, ofull, got.full);
        end
    endtask

    initial begin
        reset = 2'b11;
        inc   = '0;
        dec   = '0;
        clear = '0;
        load  = '0;
        lv0   = '0;
        lv1   = '0;
        @(posedge clockat);
        #1;
        reset = 2'b00;

        // Wrapping instance
        step(0, 1, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 0, "reset");
        step(0, 0, 1, 0, 0, 0, 12'h000, 12'h001, 0, 0, 0, "hold_inc_1");
        for (int k = 0; k < 4; k++)
            step(0, 0, 1, 0, 0, 0, 12'h000, 12'h001, 0, 0, 0, "hold_inc_n");
        step(0, 0, 0, 0, 0, 0, 12'h000, 12'h001, 0, 0, 0, "inc_release");
        step(0, 0, 0, 0, 0, 1, 12'h099, 12'h099, 0, 0, 0, "load_099");
        step(0, 0, 1, 0, 0, 0, 12'h000, 12'h100, 0, 0, 0, "inc_099_100");
        step(0, 0, 0, 0, 0, 0, 12'h000, 12'h100, 0, 0, 0, "idle_100");
        step(0, 0, 0, 1, 0, 0, 12'h000, 12'h099, 0, 0, 0, "dec_100_099");
        step(0, 0, 0, 0, 0, 1, 12'h999, 12'h999, 0, 0, 0, "load_999");
        step(0, 0, 1, 0, 0, 0, 12'h000, 12'h000, 1, 0, 0, "wrap_up");
        step(0, 0, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 0, "carry_drop");
        step(0, 0, 0, 1, 0, 0, 12'h000, 12'h999, 0, 1, 0, "wrap_down");
        step(0, 0, 0, 0, 0, 0, 12'h000, 12'h999, 0, 0, 0, "borrow_drop");
        step(0, 0, 0, 0, 0, 1, 12'h042, 12'h042, 0, 0, 0, "load_042");
        step(0, 0, 1, 1, 0, 0, 12'h000, 12'h042, 0, 0, 0, "inc_dec_same");
        step(0, 0, 0, 0, 0, 0, 12'h000, 12'h042, 0, 0, 0, "both_release");
        step(0, 0, 0, 1, 0, 0, 12'h000, 12'h041, 0, 0, 0, "dec_alone");
        step(0, 0, 0, 0, 0, 1, 12'h1A3, 12'h041, 0, 0, 1, "load_bad_digit");
        step(0, 0, 0, 0, 0, 0, 12'h000, 12'h041, 0, 0, 0, "load_err_drop");
        step(0, 0, 0, 0, 0, 1, 12'h123, 12'h123, 0, 0, 0, "load_123");
        step(0, 0, 0, 0, 1, 1, 12'h456, 12'h000, 0, 0, 0, "clear_over_load");
        step(0, 0, 1, 0, 0, 1, 12'h200, 12'h200, 0, 0, 0, "inc_during_load");
        step(0, 0, 1, 0, 0, 0, 12'h000, 12'h200, 0, 0, 0, "inc_edge_consumed");
        step(0, 0, 0, 0, 0, 1, 12'h555, 12'h555, 0, 0, 0, "load_555");
        step(0, 1, 1, 0, 0, 0, 12'h000, 12'h000, 0, 0, 0, "reset_with_inc");
        step(0, 0, 1, 0, 0, 0, 12'h000, 12'h001, 0, 0, 0, "inc_after_reset");
        step(0, 0, 1, 0, 0, 0, 12'h000, 12'h001, 0, 0, 0, "inc_held_once");
        step(0, 0, 0, 0, 0, 0, 12'h000, 12'h001, 0, 0, 0, "final_idle");

        // Saturating instance
        step(1, 1, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 0, "sat_reset");
        step(1, 0, 0, 1, 0, 0, 12'h000, 12'h000, 0, 1, 0, "sat_dec_zero");
        step(1, 0, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0, 0, "sat_borrow_drop");
        step(1, 0, 0, 0, 0, 1, 12'h999, 12'h999, 0, 0, 0, "sat_load_999");
        step(1, 0, 1, 0, 0, 0, 12'h000, 12'h999, 1, 0, 0, "sat_inc_full");
        step(1, 0, 0, 0, 0, 0, 12'h000, 12'h999, 0, 0, 0, "sat_carry_drop");
        step(1, 0, 0, 1, 0, 0, 12'h000, 12'h998, 0, 0, 0, "sat_dec_998");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_vote_counter.md
BCD_VOTE_COUNTER -- requirements
Module: bcd_vote_counter

Interface
REQ-001 SHALL have parameter DIGITS, default 3, meaning number of BCD digits (1..8).
REQ-002 SHALL have parameter WRAP, default 1, meaning 1 = wrap at full scale, 0 = saturate.
REQ-003 SHALL have parameter MAX_BCD, default all-9s over DIGITS, meaning full-scale count in packed BCD.
REQ-004 SHALL have port clockat, input, 1 bit, meaning clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit, meaning synchronous, active-high reset.
REQ-006 SHALL have port inc, input, 1 bit, meaning vote button (level); one count per rising edge of the level.
REQ-007 SHALL have port dec, input, 1 bit, meaning correction button (level); one decrement per rising edge of the level.
REQ-008 SHALL have port clear, input, 1 bit, meaning synchronous zero of count.
REQ-009 SHALL have port load, input, 1 bit, meaning load load_value this cycle.
REQ-010 SHALL have port load_value, input, 4*DIGITS bits, meaning packed BCD, digit 0 in bits [3:0].
REQ-011 SHALL have port count, output, 4*DIGITS bits, meaning packed BCD count, registered.
REQ-012 SHALL have port carry, output, 1 bit, meaning one-cycle pulse on up-wrap or up-attempt at full scale.
REQ-013 SHALL have port borrow, output, 1 bit, meaning one-cycle pulse on down-wrap or down-attempt at zero.
REQ-014 SHALL have port full, output, 1 bit, meaning count == MAX_BCD (combinational from count).
REQ-015 SHALL have port load_err, output, 1 bit, meaning one-cycle pulse when a load is rejected.

Function
REQ-016 SHALL register inc and dec into inc_q/dec_q each cycle; inc_evt = inc & ~inc_q, dec_evt = dec & ~dec_q.
REQ-017 SHALL update count at the same edge where inc_evt/dec_evt is sampled, making count visible one cycle after the button rises.
REQ-018 SHALL apply priority clear > load > (inc_evt xor dec_evt); inc_evt and dec_evt together leave count unchanged with no pulses.
REQ-019 SHALL increment per digit: a digit of 9 becomes 0 and carries into the next digit; other digits add 1; no digit ever holds 10..15.
REQ-020 SHALL decrement per digit: a digit of 0 becomes 9 and borrows from the next digit.
REQ-021 SHALL, on inc at MAX_BCD, set count to 0 and pulse carry when WRAP=1, or hold count and pulse carry when WRAP=0.
REQ-022 SHALL, on dec at 0, set count to MAX_BCD and pulse borrow when WRAP=1, or hold count at 0 and pulse borrow when WRAP=0.
REQ-023 SHALL reject a load when any digit of load_value exceeds 9 or the value exceeds MAX_BCD: count is held and load_err pulses for one cycle.
REQ-024 SHALL ignore inc_evt/dec_evt while clear or load is active, but still update inc_q/dec_q.
REQ-025 SHALL deassert carry, borrow and load_err in every cycle without their triggering event.

Reset
REQ-026 SHALL, with reset high at a clockat edge, force count=0, inc_q=0, dec_q=0, carry=0, borrow=0, load_err=0, overriding all other inputs.
REQ-027 SHALL have reset abort any in-progress operation; a button held high across reset release counts once, because inc_q=0 after reset.

Structure
REQ-028 SHALL place BCD_MAX_DIGIT=4'd9, BCD_ZERO=4'd0 and the bcd_digit_t 4-bit typedef in shared package bcd_pkg.
REQ-029 SHALL instantiate sub-module bcd_digit_step DIGITS times, one per digit, each combinational (digit, up, down, cin) -> (next_digit, cout), chained for ripple carry/borrow.
REQ-030 SHALL keep the edge-detect, priority logic and count register in bcd_vote_counter itself.

Verification (DIGITS=3 unless stated)
REQ-031 SHALL cover: reset, then hold inc high 5 cycles -> count=000 then 001 only; no further change.
REQ-032 SHALL cover: load 099, then one inc pulse -> count=100, carry=0; load 999, then inc with WRAP=1 -> count=000, carry high 1 cycle.
REQ-033 SHALL cover: with WRAP=0 at 999, inc -> count=999, carry pulse; at 000, dec -> 000, borrow pulse.
REQ-034 SHALL cover: inc and dec rising in the same cycle at 042 -> count=042, no pulses; then dec alone -> 041.
REQ-035 SHALL cover: load 1A3 -> load_err pulse, count unchanged; clear and load asserted together -> count=000.
REQ-036 SHALL cover: reset asserted while inc is high at count 555 -> count=000; inc still high after release -> count=001 once.
